// File: rtl/demux_pkg.sv
// Shared helpers for the stream demultiplexer: width math and one-hot decode.
// Purely compile-time / combinational content, no state.
// No handshake of its own; used by demux_stream and its decoder.
package demux_pkg;

    // Largest supported channel count and the index width that covers it
    localparam int MAXN = 16;
    localparam int IDXW = 4;

    // Drop counter saturates here instead of wrapping
    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Ceiling log2, used to size the channel select (v >= 2)
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Index to one-hot mask over the widest supported channel set
    function automatic logic [MAXN-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [MAXN-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/demux_onehot_dec.sv
// Select-to-channel decoder with range check for non-power-of-two N.
// Latency: 0 (combinational).
// Backpressure: none; pure function of the select.
module demux_onehot_dec
    import demux_pkg::*;
#(
    parameter int N = 4,
    localparam int SELW = clog2(N)
) (
    input  logic [SELW-1:0] iSel,
    output logic [N-1:0]    oMask,
    output logic            oInRange
);

    logic [MAXN-1:0] w_full;
    logic [MAXN-1:0] w_high;

    // Decode over the full 16-channel space; any bit above N-1 means out of range
    always_comb begin
        w_full   = onehot(IDXW'(iSel));
        w_high   = w_full >> N;
        oMask    = w_full[N-1:0];
        oInRange = (w_high == '0);
    end

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demux with broadcast; word held until all targets accept.
// Latency: 1 cycle from input accept to oValid; 1 word/cycle when targets are ready.
// Backpressure: oReady drops while any pending channel has iReady low (combinational on iReady).
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N = 4,
    localparam int SELW = clog2(N)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iData,
    input  logic [SELW-1:0]  iSel,
    input  logic             iBcast,
    input  logic             iValid,
    output logic             oReady,
    output logic [WIDTH-1:0] oData,
    output logic [N-1:0]     oValid,
    input  logic [N-1:0]     iReady,
    output logic             oErr,
    output logic [7:0]       oDrop
);

    logic [N-1:0]     r_pend;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic [7:0]       r_drop;

    logic [N-1:0]     w_mask;
    logic             w_in_range;
    logic             w_ready;
    logic             w_accept;

    demux_onehot_dec #(
        .N (N)
    ) u_dec (
        .iSel     (iSel),
        .oMask    (w_mask),
        .oInRange (w_in_range)
    );

    // Free for a new word once every still-pending channel completes this cycle
    always_comb begin
        w_ready  = ((r_pend & ~iReady) == '0);
        w_accept = iValid & w_ready;
    end

    // Pending mask and held word; a new accept overrides same-edge completion clears
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_pend <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            if (iBcast) begin
                r_pend <= '1;
                r_data <= iData;
            end else if (w_in_range) begin
                r_pend <= w_mask;
                r_data <= iData;
            end else begin
                r_pend <= '0;
            end
        end else begin
            r_pend <= r_pend & ~iReady;
        end
    end

    // Sticky error flag and saturating drop counter for out-of-range selects
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_err  <= 1'b0;
            r_drop <= '0;
        end else if (w_accept && !iBcast && !w_in_range) begin
            r_err <= 1'b1;
            if (r_drop != DROP_MAX) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign oReady = w_ready;
    assign oData  = r_data;
    assign oValid = r_pend;
    assign oErr   = r_err;
    assign oDrop  = r_drop;

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

    logic iClk;
    logic iRst;

    // Instance A: N=4, WIDTH=8
    logic [7:0] a_data;
    logic [1:0] a_sel;
    logic       a_bcast;
    logic       a_valid;
    logic       a_oready;
    logic [7:0] a_odata;
    logic [3:0] a_ovalid;
    logic [3:0] a_rdy;
    logic       a_oerr;
    logic [7:0] a_odrop;

    // Instance B: N=5, WIDTH=8 (select 5..7 out of range)
    logic [7:0] b_data;
    logic [2:0] b_sel;
    logic       b_bcast;
    logic       b_valid;
    logic       b_oready;
    logic [7:0] b_odata;
    logic [4:0] b_ovalid;
    logic [4:0] b_rdy;
    logic       b_oerr;
    logic [7:0] b_odrop;

    int n_cmp;
    int n_err;

    // Reference model for A: per-channel queue of words still owed to that channel
    logic [7:0] mq [4][$];

    demux_stream #(.WIDTH(8), .N(4)) dut_a (
        .iClk(iClk), .iRst(iRst), .iData(a_data), .iSel(a_sel), .iBcast(a_bcast),
        .iValid(a_valid), .oReady(a_oready), .oData(a_odata), .oValid(a_ovalid),
        .iReady(a_rdy), .oErr(a_oerr), .oDrop(a_odrop)
    );

    demux_stream #(.WIDTH(8), .N(5)) dut_b (
        .iClk(iClk), .iRst(iRst), .iData(b_data), .iSel(b_sel), .iBcast(b_bcast),
        .iValid(b_valid), .oReady(b_oready), .oData(b_odata), .oValid(b_ovalid),
        .iReady(b_rdy), .oErr(b_oerr), .oDrop(b_odrop)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // One clock: advance the A model with the inputs present at the rising edge
    task automatic tick();
        bit mrdy;
        @(posedge iClk);
        if (!iRst) begin
            mrdy = 1'b1;
            for (int k = 0; k < 4; k++) if (mq[k].size() != 0 && !a_rdy[k]) mrdy = 1'b0;
            for (int k = 0; k < 4; k++) if (mq[k].size() != 0 && a_rdy[k]) void'(mq[k].pop_front());
            if (a_valid && mrdy) begin
                if (a_bcast) begin
                    for (int k = 0; k < 4; k++) mq[k].push_back(a_data);
                end else begin
                    mq[a_sel].push_back(a_data);
                end
            end
        end
        @(negedge iClk);
    endtask

    task automatic test_reset();
        n_cmp++; if (a_ovalid !== 4'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0000", a_ovalid); end
        n_cmp++; if (a_odata !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", a_odata); end
        n_cmp++; if (a_oready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", a_oready); end
        n_cmp++; if (a_oerr !== 1'b0 || a_odrop !== 8'd0) begin n_err++; $display("FAIL reset_err: got err=%b drop=%0d want 0/0", a_oerr, a_odrop); end
        n_cmp++; if (b_ovalid !== 5'b0 || b_oready !== 1'b1) begin n_err++; $display("FAIL reset_b: got valid=%b ready=%b want 00000/1", b_ovalid, b_oready); end
    endtask

    task automatic test_single();
        a_rdy = 4'hF; a_bcast = 1'b0; a_valid = 1'b1; a_sel = 2'd2; a_data = 8'hA5;
        #1;
        n_cmp++; if (a_oready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", a_oready); end
        tick();
        a_valid = 1'b0;
        #1;
        n_cmp++; if (a_ovalid !== 4'b0100) begin n_err++; $display("FAIL single_valid: got %b want 0100", a_ovalid); end
        n_cmp++; if (a_odata !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", a_odata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ev;
        a_rdy = 4'hF; a_bcast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_sel = 2'(i); a_data = 8'(i + 1);
            #1;
            n_cmp++; if (a_oready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, a_oready); end
            if (i > 0) begin
                ev = 4'b0001 << (i - 1);
                n_cmp++; if (a_ovalid !== ev || a_odata !== 8'(i)) begin n_err++; $display("FAIL b2b_out[%0d]: got %b/%h want %b/%h", i, a_ovalid, a_odata, ev, 8'(i)); end
            end
            tick();
        end
        a_valid = 1'b0;
        #1;
        n_cmp++; if (a_ovalid !== 4'b1000 || a_odata !== 8'h04) begin n_err++; $display("FAIL b2b_last: got %b/%h want 1000/04", a_ovalid, a_odata); end
        tick();
    endtask

    task automatic test_backpressure();
        a_rdy = 4'b1101; a_bcast = 1'b0; a_valid = 1'b1; a_sel = 2'd1; a_data = 8'h77;
        tick();
        a_sel = 2'd0; a_data = 8'h88;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (a_ovalid !== 4'b0010 || a_oready !== 1'b0 || a_odata !== 8'h77) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b r=%b d=%h want 0010/0/77", c, a_ovalid, a_oready, a_odata);
            end
            tick();
        end
        a_rdy = 4'hF;
        #1;
        n_cmp++; if (a_oready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b want 1", a_oready); end
        tick();
        a_valid = 1'b0;
        #1;
        n_cmp++; if (a_ovalid !== 4'b0001 || a_odata !== 8'h88) begin n_err++; $display("FAIL bp_next: got %b/%h want 0001/88", a_ovalid, a_odata); end
        tick();
    endtask

    task automatic test_broadcast();
        logic [3:0] rseq [4];
        logic [3:0] vseq [4];
        logic       oseq [4];
        rseq = '{4'b0001, 4'b1000, 4'b0010, 4'b0100};
        vseq = '{4'b1111, 4'b1110, 4'b0110, 4'b0100};
        oseq = '{1'b0, 1'b0, 1'b0, 1'b1};
        a_rdy = 4'hF; a_bcast = 1'b1; a_valid = 1'b1; a_data = 8'h3C; a_sel = 2'd0;
        tick();
        a_valid = 1'b0; a_bcast = 1'b0;
        for (int s = 0; s < 4; s++) begin
            a_rdy = rseq[s];
            #1;
            n_cmp++; if (a_ovalid !== vseq[s] || a_oready !== oseq[s] || a_odata !== 8'h3C) begin
                n_err++; $display("FAIL bcast[%0d]: got v=%b r=%b d=%h want %b/%b/3c", s, a_ovalid, a_oready, a_odata, vseq[s], oseq[s]);
            end
            tick();
        end
        #1;
        n_cmp++; if (a_ovalid !== 4'b0000) begin n_err++; $display("FAIL bcast_done: got %b want 0000", a_ovalid); end
    endtask

    task automatic test_random(input int cycles);
        bit mrdy;
        bit any;
        logic [7:0] ed;
        logic [3:0] ev;
        for (int i = 0; i < cycles; i++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_bcast = ($urandom_range(0, 3) == 0);
            a_sel   = 2'($urandom_range(0, 3));
            a_data  = 8'($urandom);
            a_rdy   = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            mrdy = 1'b1; any = 1'b0; ev = '0; ed = '0;
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() != 0) begin
                    ev[k] = 1'b1; any = 1'b1; ed = mq[k][0];
                    if (!a_rdy[k]) mrdy = 1'b0;
                end
            end
            #1;
            n_cmp++; if (a_ovalid !== ev || a_oready !== mrdy) begin
                n_err++; $display("FAIL rand_hs[%0d]: got v=%b r=%b want %b/%b", i, a_ovalid, a_oready, ev, mrdy);
            end
            if (any) begin
                n_cmp++; if (a_odata !== ed) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", i, a_odata, ed); end
            end
            tick();
        end
        a_valid = 1'b0; a_rdy = 4'hF;
        tick();
    endtask

    task automatic test_drop();
        b_rdy = 5'h1F; b_bcast = 1'b0; b_valid = 1'b1; b_sel = 3'd1; b_data = 8'h9A;
        tick();
        b_sel = 3'd6; b_data = 8'h11;
        tick();
        #1;
        n_cmp++; if (b_ovalid !== 5'b0) begin n_err++; $display("FAIL drop_valid1: got %b want 00000", b_ovalid); end
        b_sel = 3'd7; b_data = 8'h22;
        tick();
        b_valid = 1'b0;
        #1;
        n_cmp++; if (b_ovalid !== 5'b0 || b_oerr !== 1'b1 || b_odrop !== 8'd2 || b_odata !== 8'h9A) begin
            n_err++; $display("FAIL drop_two: got v=%b e=%b n=%0d d=%h want 00000/1/2/9a", b_ovalid, b_oerr, b_odrop, b_odata);
        end
        b_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b_sel = 3'(5 + (i % 3)); b_data = 8'(i);
            tick();
        end
        b_valid = 1'b0;
        #1;
        n_cmp++; if (b_odrop !== 8'd255 || b_oerr !== 1'b1 || b_odata !== 8'h9A) begin
            n_err++; $display("FAIL drop_sat: got n=%0d e=%b d=%h want 255/1/9a", b_odrop, b_oerr, b_odata);
        end
    endtask

    task automatic test_async_reset();
        a_rdy = 4'hF; a_bcast = 1'b1; a_valid = 1'b1; a_data = 8'hE7;
        tick();
        a_valid = 1'b0; a_bcast = 1'b0; a_rdy = 4'b0101;
        tick();
        a_rdy = 4'b0000;
        #1;
        n_cmp++; if (a_ovalid !== 4'b1010) begin n_err++; $display("FAIL arst_pre: got %b want 1010", a_ovalid); end
        #1 iRst = 1'b1;
        #1;
        n_cmp++; if (a_ovalid !== 4'b0 || a_odata !== 8'h00 || a_oready !== 1'b1) begin
            n_err++; $display("FAIL arst_now: got v=%b d=%h r=%b want 0000/00/1", a_ovalid, a_odata, a_oready);
        end
        n_cmp++; if (b_odrop !== 8'd0 || b_oerr !== 1'b0) begin n_err++; $display("FAIL arst_err: got n=%0d e=%b want 0/0", b_odrop, b_oerr); end
        for (int k = 0; k < 4; k++) mq[k].delete();
        #1 iRst = 1'b0;
        @(negedge iClk);
        a_rdy = 4'hF; a_valid = 1'b1; a_sel = 2'd3; a_data = 8'h6B;
        tick();
        a_valid = 1'b0;
        #1;
        n_cmp++; if (a_ovalid !== 4'b1000 || a_odata !== 8'h6B) begin n_err++; $display("FAIL arst_after: got %b/%h want 1000/6b", a_ovalid, a_odata); end
        tick();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        iRst = 1'b1;
        a_data = '0; a_sel = '0; a_bcast = 1'b0; a_valid = 1'b0; a_rdy = '0;
        b_data = '0; b_sel = '0; b_bcast = 1'b0; b_valid = 1'b0; b_rdy = '0;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        #1;
        test_reset();
        @(negedge iClk);
        test_single();
        test_back_to_back();
        test_backpressure();
        test_broadcast();
        test_random(400);
        test_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
# demux_stream

Parametrised, registered 1-to-N stream demultiplexer with per-channel valid/ready handshakes and a broadcast mode. It supersedes the combinational 1-to-4 selector wherever routed data must cross into back-pressured consumers, for example lab datapaths feeding several display/LED sinks from one source. One input word is routed to the addressed channel, or to all channels in broadcast. The word is held until every target channel has accepted it.

## Interface
- `WIDTH`, 8, data width in bits
- `N`, 4, number of output channels (2..16; need not be a power of two)
- `SELW`, `clog2(N)`, select width (derived, not overridden)

Ports:
- `iClk` input 1 — clock, rising edge
- `iRst` input 1 — asynchronous, active-high reset
- `iData` input WIDTH — input word
- `iSel` input SELW — destination channel index
- `iBcast` input 1 — 1: send to all N channels; `iSel` ignored
- `iValid` input 1 — input word valid
- `oReady` output 1 — block can take an input word this cycle
- `oData` output WIDTH — held word, shared by all channels
- `oValid` output N — bit k: word pending for channel k
- `iReady` input N — bit k: channel k accepts this cycle
- `oErr` output 1 — sticky: an out-of-range `iSel` was received
- `oDrop` output 8 — saturating count of dropped (out-of-range) words

## Operation
- Internal state is a pending mask `pend[N-1:0]` plus a data register. `oValid = pend`.
- Channel k completes when `pend[k] & iReady[k]`. `pend[k]` clears at that edge.
- `oReady = ((pend & ~iReady) == 0)`, meaning every pending channel completes this cycle. This allows back-to-back words at full rate.
- Input accept happens when `iValid & oReady`:
  - `iBcast=1`: `pend <= all ones`.
  - `iBcast=0` and `iSel < N`: `pend <= onehot(iSel)`.
  - `iBcast=0` and `iSel >= N`: `pend <= 0`, `oErr <= 1`, `oDrop` increments, saturating at 255.
  - `oData <= iData`, except on a drop, where `oData` holds its previous value.
- On an accept, the new `pend` overrides the completion clears of the same edge.
- `oData` is stable whenever `pend != 0`.
- In broadcast, channels may accept in any order and in different cycles. The next word waits for the slowest channel.
- `iReady[k]` while `pend[k]=0` has no effect.
- `oErr` and `oDrop` clear only on reset.

## Timing
- Reset values: `pend=0`, so `oValid=0`; `oData=0`, `oErr=0`, `oDrop=0`, and `oReady=1` (combinational from `pend=0`).
- An asynchronous reset mid-transfer discards the held word immediately, including any partially delivered broadcast. No completion is reported afterwards.
- Latency: a word accepted at edge t appears as `oValid[k]=1` in cycle t+1.
- Throughput: 1 word/cycle when targets hold `iReady` high. A broadcast with all `iReady` high also runs at 1 word/cycle.
- `oReady` depends combinationally on `iReady`. This is the only combinational input-to-output path. The path `iValid` → `oValid` is fully registered.
- A drop still consumes one accept cycle; `oValid` stays 0 in the following cycle.

## Structure
- Package `demux_pkg`:
  - `clog2` function for `SELW`;
  - `onehot` function (index → N-bit mask);
  - localparam `DROP_MAX = 8'hFF`.
- Sub-module `demux_onehot_dec`: a combinational `SELW`→N decoder with range check. It outputs `mask[N-1:0]` and `inRange`.
- The top holds the `pend`/data registers, handshake logic and the error counter.

## Test plan
- Reset, then N=4, WIDTH=8, all `iReady=1`. Send `iData=8'hA5`, `iSel=2` → next cycle `oValid=4'b0100`, `oData=8'hA5`. Send back-to-back `8'h01..8'h04` to `iSel=0..3` → one word per cycle, `oReady` stays 1.
- Back-pressure: `iReady[1]=0` and word to ch1 → `oValid=4'b0010` held and `oReady=0` for 5 cycles. Raise `iReady[1]` → `oReady=1` in the same cycle, `pend` clears at that edge.
- Broadcast `8'h3C` with `iReady` asserted for ch0, ch3, ch1, ch2 in successive cycles → `oValid` goes 1111→1110→0110→0100→0000. `oReady` rises only in the ch2 cycle, and `oData` holds `8'h3C` throughout.
- N=5 (SELW=3): send `iSel=6`, then `iSel=7` → `oValid` stays 0, `oErr=1`, `oDrop=2`, `oData` unchanged. 256 further drops → `oDrop=255`.
- Assert `iRst` while a broadcast is partially delivered (`pend=4'b1010`) → `oValid=0`, `oData=0` and `oReady=1` immediately (asynchronous), with no clock edge needed. After release, the first new word routes normally.
